// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port Memory (combinational read, synchronous write)
//   between instruction fetch (port 0) and load/store (port 1). One port is
//   granted per access; the memory control, address and write data are driven
//   from registers. Read data is captured into rdata with a per-port rvalid
//   pulse.
//
// Ports
//   clock        rising-edge clock
//   reset_L      asynchronous active-low reset
//   req[1:0]     per-port request, level-held until granted
//   we[1:0]      per-port write (1) / read (0), valid with req
//   lock[1:0]    per-port keep-ownership hint, sampled with req
//   addr[1:0]    per-port address
//   wdata[1:0]   per-port write data
//   gnt          one-hot grant pulse, one cycle
//   rvalid       one-hot read-data-valid pulse, one cycle
//   rdata        captured read data, shared by both ports
//   busy         high while an access is in flight
//   mem_re       Memory read enable
//   mem_we       Memory write enable
//   mem_addr     Memory address
//   mem_wdata    Memory write data (top level drives the Data bus only while mem_we=1)
//   mem_rdata    Memory data as read
//
// Configuration
//   MEM_ARB_FIXED_PRI_EN  defined: port 0 always wins ties; lock and the
//                         last-owner history are unused (port 1 may starve).
//                         undefined: round-robin ties with sticky lock.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; winner is latched on the edge leaving
// ACCESS | memory sees the registered controls for exactly one cycle;
//        | read data is captured and the write commits on the next edge

module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          lock,
  input  logic [1:0][AW-1:0]  addr,
  input  logic [1:0][DW-1:0]  wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                mem_re,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   win;
  logic   owner;

`ifdef MEM_ARB_FIXED_PRI_EN
  logic   unused_lock;
  assign unused_lock = ^lock;
`else
  logic   last_owner;
  logic   lock_vld;
  logic   lock_port;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and winner selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    win       = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (req == 2'b10) begin
      win = 1'b1;
    end else if (req == 2'b01) begin
      win = 1'b0;
    end else begin
`ifdef MEM_ARB_FIXED_PRI_EN
      win = 1'b0;
`else
      // A held lock overrides round-robin only on a tie; a lone request from
      // the other port is never blocked.
      win = lock_vld ? lock_port : ~last_owner;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registered memory controls, grant and read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
    end else begin
      rvalid <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            mem_addr  <= addr[win];
            mem_wdata <= wdata[win];
            mem_we    <= we[win];
            mem_re    <= ~we[win];
            gnt       <= win ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            owner     <= win;
          end
        end
        ACCESS: begin
          if (mem_re) begin
            rdata  <= mem_rdata;
            rvalid <= owner ? 2'b10 : 2'b01;
          end
          gnt    <= 2'b00;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          gnt    <= 2'b00;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifndef MEM_ARB_FIXED_PRI_EN
  // ---------------------------------------------------------------------------
  // Tie-break history: last owner and sticky lock
  // ---------------------------------------------------------------------------
  // The most recent grant taken with its lock bit set owns the lock. A grant
  // to the lock holder without its lock bit releases it; a grant to the other
  // port without lock leaves the holder's lock in place.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      last_owner <= 1'b1;
      lock_vld   <= 1'b0;
      lock_port  <= 1'b0;
    end else if (state == IDLE && req != 2'b00) begin
      last_owner <= win;
      if (lock[win]) begin
        lock_vld  <= 1'b1;
        lock_port <= win;
      end else if (lock_vld && lock_port == win) begin
        lock_vld  <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output invariants
  // ---------------------------------------------------------------------------
  a_re_we_excl: assert property (@(posedge clock) disable iff (!reset_L)
    !(mem_re && mem_we));
  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset_L)
    $onehot0(gnt));
  a_rvalid_onehot: assert property (@(posedge clock) disable iff (!reset_L)
    $onehot0(rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef MEM_ARB_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset_L = 1'b0;
  logic [1:0]          req = '0;
  logic [1:0]          we = '0;
  logic [1:0]          lock = '0;
  logic [1:0][AW-1:0]  addr = '0;
  logic [1:0][DW-1:0]  wdata = '0;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                mem_re;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_L(reset_L), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .busy(busy), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory: combinational read, synchronous write, plus a preload port.
  logic [DW-1:0] mem_arr [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clock) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mem_we) mem_arr[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_arr[mem_addr];

  int we_cnt = 0;
  int both_cnt = 0;
  always @(negedge clock) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end

  // Reference model: transaction-level arbitration rules and memory contents.
  logic [DW-1:0] exp_mem [256];
  int            m_last;
  bit            m_lock_vld;
  int            m_lock_port;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  typedef struct {
    logic [1:0]    gnt;
    logic          busy;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt2;
    logic          busy2;
  } obs_t;

  task automatic model_reset();
    m_last = 1;
    m_lock_vld = 0;
    m_lock_port = 0;
    m_rdata = '0;
    m_addr = '0;
    m_wdata = '0;
  endtask

  task automatic model_step(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                            input logic [1:0][AW-1:0] a, input logic [1:0][DW-1:0] d,
                            output logic [1:0] e_gnt, output logic e_we, output logic e_re,
                            output logic [1:0] e_rv);
    int win;
    e_gnt = 2'b00; e_we = 1'b0; e_re = 1'b0; e_rv = 2'b00;
    if (rq == 2'b00) return;
    if (rq == 2'b01) win = 0;
    else if (rq == 2'b10) win = 1;
    else if (FIXED_PRI) win = 0;
    else if (m_lock_vld) win = m_lock_port;
    else win = 1 - m_last;
    e_gnt = (win == 1) ? 2'b10 : 2'b01;
    e_we = w[win];
    e_re = !w[win];
    m_addr = a[win];
    m_wdata = d[win];
    if (w[win]) exp_mem[m_addr] = m_wdata;
    else begin
      m_rdata = exp_mem[m_addr];
      e_rv = e_gnt;
    end
    m_last = win;
    if (lk[win]) begin
      m_lock_vld = 1;
      m_lock_port = win;
    end else if (m_lock_vld && m_lock_port == win) begin
      m_lock_vld = 0;
    end
  endtask

  // One arbitration slot: drive at E0-, sample grant phase after E0, read phase after E1.
  task automatic do_access(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                           input logic [1:0][AW-1:0] a, input logic [1:0][DW-1:0] d,
                           output obs_t o);
    req = rq; we = w; lock = lk; addr = a; wdata = d;
    @(posedge clock); #1;
    o.gnt = gnt; o.busy = busy; o.mem_we = mem_we; o.mem_re = mem_re;
    o.maddr = mem_addr; o.mwdata = mem_wdata;
    req = '0; we = '0; lock = '0;
    @(posedge clock); #1;
    o.rvalid = rvalid; o.rdata = rdata; o.gnt2 = gnt; o.busy2 = busy;
  endtask

  task automatic fresh_reset();
    req = '0; we = '0; lock = '0;
    reset_L = 1'b0;
    model_reset();
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    obs_t o;
    logic [1:0] eg, erv;
    logic ewe, ere;
    req = 2'($urandom); we = 2'($urandom); lock = 2'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    #3;
    checks++;
    if ({gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h busy=%b re=%b we=%b addr=%h wdata=%h, expected all 0",
               gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata);
    end
    fresh_reset();
    model_step(2'b01, 2'b00, 2'b00, {8'h00, 8'h10}, 16'h0, eg, ewe, ere, erv);
    do_access(2'b01, 2'b00, 2'b00, {8'h00, 8'h10}, 16'h0, o);
    checks++;
    if (o.rvalid !== 2'b01 || o.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL reset_pre_read: got rvalid=%b rdata=%h, expected 01 a5", o.rvalid, o.rdata);
    end
    req = 2'($urandom); we = 2'($urandom); lock = 2'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_async: got gnt=%b rvalid=%b rdata=%h busy=%b re=%b we=%b addr=%h wdata=%h, expected all 0",
               gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata);
    end
    req = '0; we = '0; lock = '0;
    @(negedge clock);
    reset_L = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got gnt=%b busy=%b, expected 00 0", gnt, busy);
    end
  endtask

  task automatic test_port0_read();
    obs_t o;
    logic [1:0] eg, erv;
    logic ewe, ere;
    model_step(2'b01, 2'b00, 2'b00, {8'h00, 8'h10}, 16'h0, eg, ewe, ere, erv);
    do_access(2'b01, 2'b00, 2'b00, {8'h00, 8'h10}, 16'h0, o);
    checks++;
    if (o.gnt !== 2'b01 || o.busy !== 1'b1 || o.mem_re !== 1'b1 || o.mem_we !== 1'b0 || o.maddr !== 8'h10) begin
      errors++;
      $display("FAIL p0_read_grant: got gnt=%b busy=%b re=%b we=%b addr=%h, expected 01 1 1 0 10",
               o.gnt, o.busy, o.mem_re, o.mem_we, o.maddr);
    end
    checks++;
    if (o.rvalid !== 2'b01 || o.rdata !== 8'hA5 || o.gnt2 !== 2'b00 || o.busy2 !== 1'b0) begin
      errors++;
      $display("FAIL p0_read_data: got rvalid=%b rdata=%h gnt=%b busy=%b, expected 01 a5 00 0",
               o.rvalid, o.rdata, o.gnt2, o.busy2);
    end
  endtask

  task automatic test_write_read();
    obs_t o;
    logic [1:0] eg, erv;
    logic ewe, ere;
    int we0;
    we0 = we_cnt;
    model_step(2'b10, 2'b10, 2'b00, {8'h20, 8'h00}, {8'h3C, 8'h00}, eg, ewe, ere, erv);
    do_access(2'b10, 2'b10, 2'b00, {8'h20, 8'h00}, {8'h3C, 8'h00}, o);
    checks++;
    if (o.gnt !== 2'b10 || o.mem_we !== 1'b1 || o.mem_re !== 1'b0 || o.maddr !== 8'h20 ||
        o.mwdata !== 8'h3C || o.rvalid !== 2'b00) begin
      errors++;
      $display("FAIL p1_write: got gnt=%b we=%b re=%b addr=%h wdata=%h rvalid=%b, expected 10 1 0 20 3c 00",
               o.gnt, o.mem_we, o.mem_re, o.maddr, o.mwdata, o.rvalid);
    end
    model_step(2'b01, 2'b00, 2'b00, {8'h00, 8'h20}, 16'h0, eg, ewe, ere, erv);
    do_access(2'b01, 2'b00, 2'b00, {8'h00, 8'h20}, 16'h0, o);
    checks++;
    if (o.gnt !== 2'b01 || o.rvalid !== 2'b01 || o.rdata !== 8'h3C) begin
      errors++;
      $display("FAIL p0_readback: got gnt=%b rvalid=%b rdata=%h, expected 01 01 3c", o.gnt, o.rvalid, o.rdata);
    end
    checks++;
    if (we_cnt - we0 != 1 || both_cnt != 0) begin
      errors++;
      $display("FAIL we_pulse: got we_cycles=%0d both_high=%0d, expected 1 0", we_cnt - we0, both_cnt);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [1:0] eg, erv, lit;
    logic ewe, ere;
    logic [1:0][AW-1:0] a;
    fresh_reset();
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      model_step(2'b11, 2'b00, 2'b00, a, 16'h0, eg, ewe, ere, erv);
      do_access(2'b11, 2'b00, 2'b00, a, 16'h0, o);
      lit = (FIXED_PRI || (i % 2 == 0)) ? 2'b01 : 2'b10;
      checks++;
      if (o.gnt !== lit || o.gnt !== eg) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, expected %b", i, o.gnt, lit);
      end
      checks++;
      if (o.rvalid !== erv || o.rdata !== m_rdata) begin
        errors++;
        $display("FAIL rr_read[%0d]: got rvalid=%b rdata=%h, expected %b %h", i, o.rvalid, o.rdata, erv, m_rdata);
      end
    end
  endtask

  task automatic test_lock();
    obs_t o;
    logic [1:0] eg, erv, lit;
    logic ewe, ere;
    logic [1:0] rqs [7];
    logic [1:0] lks [7];
    logic [1:0] lit_rr [7];
    logic [1:0][AW-1:0] a;
    rqs    = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    lks    = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    lit_rr = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    fresh_reset();
    for (int i = 0; i < 7; i++) begin
      a = 16'($urandom);
      model_step(rqs[i], 2'b00, lks[i], a, 16'h0, eg, ewe, ere, erv);
      do_access(rqs[i], 2'b00, lks[i], a, 16'h0, o);
      lit = FIXED_PRI ? 2'b01 : lit_rr[i];
      checks++;
      if (o.gnt !== lit || o.gnt !== eg) begin
        errors++;
        $display("FAIL lock_grant[%0d]: got %b, expected %b", i, o.gnt, lit);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    logic [1:0] eg, erv;
    logic ewe, ere;
    req = 2'b10; we = 2'b10; lock = 2'b00; addr = {8'h40, 8'h00}; wdata = {8'hEE, 8'h00};
    @(posedge clock); #1;
    checks++;
    if (mem_we !== 1'b1 || gnt !== 2'b10) begin
      errors++;
      $display("FAIL midrst_start: got we=%b gnt=%b, expected 1 10", mem_we, gnt);
    end
    req = '0; we = '0;
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mem_we !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got we=%b gnt=%b busy=%b, expected 0 00 0", mem_we, gnt, busy);
    end
    @(posedge clock); #1;
    checks++;
    if (rvalid !== 2'b00) begin
      errors++;
      $display("FAIL midrst_rvalid: got %b, expected 00", rvalid);
    end
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock); #1;
    model_step(2'b01, 2'b00, 2'b00, {8'h00, 8'h40}, 16'h0, eg, ewe, ere, erv);
    do_access(2'b01, 2'b00, 2'b00, {8'h00, 8'h40}, 16'h0, o);
    checks++;
    if (o.rvalid !== 2'b01 || o.rdata !== 8'h11) begin
      errors++;
      $display("FAIL midrst_nocommit: got rvalid=%b rdata=%h, expected 01 11", o.rvalid, o.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0] eg, erv, rq, w, lk;
    logic ewe, ere;
    logic [1:0][AW-1:0] a;
    logic [1:0][DW-1:0] d;
    for (int i = 0; i < 60; i++) begin
      rq = 2'($urandom); w = 2'($urandom); lk = 2'($urandom);
      a = 16'($urandom); d = 16'($urandom);
      model_step(rq, w, lk, a, d, eg, ewe, ere, erv);
      do_access(rq, w, lk, a, d, o);
      checks++;
      if (o.gnt !== eg || o.busy !== (rq != 2'b00) || o.mem_we !== ewe || o.mem_re !== ere) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got gnt=%b busy=%b we=%b re=%b, expected %b %b %b %b",
                 i, o.gnt, o.busy, o.mem_we, o.mem_re, eg, (rq != 2'b00), ewe, ere);
      end
      checks++;
      if (o.maddr !== m_addr || o.mwdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_mem_bus[%0d]: got addr=%h wdata=%h, expected %h %h", i, o.maddr, o.mwdata, m_addr, m_wdata);
      end
      checks++;
      if (o.rvalid !== erv || o.rdata !== m_rdata || o.gnt2 !== 2'b00 || o.busy2 !== 1'b0) begin
        errors++;
        $display("FAIL rand_read[%0d]: got rvalid=%b rdata=%h gnt=%b busy=%b, expected %b %h 00 0",
                 i, o.rvalid, o.rdata, o.gnt2, o.busy2, erv, m_rdata);
      end
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL re_we_exclusive: got %0d overlapping cycles, expected 0", both_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_addr = 8'(i);
      if (i == 8'h10) pl_data = 8'hA5;
      else if (i == 8'h40) pl_data = 8'h11;
      else pl_data = 8'($urandom);
      exp_mem[i] = pl_data;
      @(posedge clock); #1;
    end
    pl_en = 1'b0;
    test_reset();
    test_port0_read();
    test_write_read();
    test_round_robin();
    test_lock();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
